divider_16x8_seq: RTL and testbench



---
 rtl/div_pkg.sv | 31 +++
 rtl/divider_16x8_seq_if.sv | 27 ++
 rtl/div_restore_step.sv | 25 ++
 rtl/divider_16x8_seq.sv | 131 +++++++++++++
 tb/tb_divider_16x8_seq.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types, widths and helpers for the 16x8 sequential divider
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // One restoring iteration per dividend bit; not meant to be changed.
  localparam int ITER   = 16;
  localparam int CNT_W  = $clog2(ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  localparam int MAG_W  = 16;  // dividend / quotient magnitude width
  localparam int PREM_W = 9;   // partial remainder width
  localparam int DIV_W  = 8;   // divisor width

  localparam logic [7:0] DBZ_QUOTIENT = 8'hFF;

  // Absolute value when the operand is treated as signed; -32768 stays 0x8000.
  function automatic logic [MAG_W-1:0] mag16(input logic [MAG_W-1:0] v, input logic s);
    return (s && v[MAG_W-1]) ? (~v + 16'd1) : v;
  endfunction

  // Absolute value of the divisor when signed; -128 stays 0x80.
  function automatic logic [DIV_W-1:0] mag8(input logic [DIV_W-1:0] v, input logic s);
    return (s && v[DIV_W-1]) ? (~v + 8'd1) : v;
  endfunction

endpackage

// File: rtl/divider_16x8_seq_if.sv
// rtl/divider_16x8_seq_if.sv - request/result bundle of the sequential divider
interface divider_16x8_seq_if;

  logic        Start;
  logic        Sign;
  logic [15:0] Dividend;
  logic [7:0]  Divisor;
  logic [7:0]  Quotient;
  logic [7:0]  Remainder;
  logic        Overflow;
  logic        Div_By_Zero;
  logic        Busy;
  logic        Done;

  // Requester side: issues operands, observes results.
  modport master (
    output Start, Sign, Dividend, Divisor,
    input  Quotient, Remainder, Overflow, Div_By_Zero, Busy, Done
  );

  // Divider side.
  modport slave (
    input  Start, Sign, Dividend, Divisor,
    output Quotient, Remainder, Overflow, Div_By_Zero, Busy, Done
  );

endinterface

// File: rtl/div_restore_step.sv
// rtl/div_restore_step.sv - one restoring division step (shift, trial subtract, keep)
module div_restore_step
  import div_pkg::*;
(
  input  logic [PREM_W-1:0] i_prem,
  input  logic              i_bit,
  input  logic [DIV_W-1:0]  i_divisor,
  output logic [PREM_W-1:0] o_prem,
  output logic              o_qbit
);

  logic [PREM_W:0]   w_wide;
  logic [PREM_W-1:0] w_shift;
  logic              w_ge;

  // Shift in the next dividend bit and keep the difference only if it does not go negative.
  always_comb begin
    w_wide  = {i_prem, i_bit};
    w_shift = w_wide[PREM_W-1:0];
    w_ge    = (w_wide >= {2'b00, i_divisor});
    o_qbit  = w_ge;
    o_prem  = w_ge ? (w_shift - {1'b0, i_divisor}) : w_shift;
  end

endmodule

// File: rtl/divider_16x8_seq.sv
// rtl/divider_16x8_seq.sv - iterative restoring 16/8 divider, signed or unsigned per request
module divider_16x8_seq
  import div_pkg::*;
(
  input  logic               Clk,
  input  logic               Rst,
  divider_16x8_seq_if.slave  bus
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [MAG_W-1:0]   r_q;       // dividend magnitude shifting out, quotient shifting in
  logic [PREM_W-1:0]  r_prem;
  logic [DIV_W-1:0]   r_div;
  logic               r_sign;
  logic               r_qneg;
  logic               r_rneg;
  logic               r_dbz;
  logic [7:0]         r_quot;
  logic [7:0]         r_rem;
  logic               r_ovf;
  logic               r_dbz_out;
  logic               r_busy;
  logic               r_done;

  logic [PREM_W-1:0]  w_prem_nxt;
  logic               w_qbit;
  logic [7:0]         w_quot;
  logic [7:0]         w_rem;
  logic               w_ovf;

  div_restore_step u_step (
    .i_prem    (r_prem),
    .i_bit     (r_q[MAG_W-1]),
    .i_divisor (r_div),
    .o_prem    (w_prem_nxt),
    .o_qbit    (w_qbit)
  );

  // Sign fix-up and range check on the finished magnitudes; low byte of the negation is enough.
  always_comb begin
    w_quot = r_qneg ? (8'd0 - r_q[7:0]) : r_q[7:0];
    w_rem  = r_rneg ? (8'd0 - r_prem[7:0]) : r_prem[7:0];
    if (r_sign) begin
      w_ovf = r_qneg ? (r_q > 16'd128) : (r_q > 16'd127);
    end else begin
      w_ovf = (r_q > 16'd255);
    end
  end

  // Control FSM: capture operands, iterate, then publish results with a one-cycle Done.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_q       <= '0;
      r_prem    <= '0;
      r_div     <= '0;
      r_sign    <= 1'b0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_dbz     <= 1'b0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_ovf     <= 1'b0;
      r_dbz_out <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.Start) begin
            r_busy <= 1'b1;
            r_sign <= bus.Sign;
            r_qneg <= bus.Sign & (bus.Dividend[15] ^ bus.Divisor[7]);
            r_rneg <= bus.Sign & bus.Dividend[15];
            r_div  <= mag8(bus.Divisor, bus.Sign);
            r_prem <= '0;
            r_cnt  <= '0;
            if (bus.Divisor == 8'd0) begin
              // Raw dividend is kept so its low byte can be returned as the remainder.
              r_dbz   <= 1'b1;
              r_q     <= bus.Dividend;
              r_state <= FIX;
            end else begin
              r_dbz   <= 1'b0;
              r_q     <= mag16(bus.Dividend, bus.Sign);
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_prem <= w_prem_nxt;
          r_q    <= {r_q[MAG_W-2:0], w_qbit};
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          if (r_dbz) begin
            r_quot    <= DBZ_QUOTIENT;
            r_rem     <= r_q[7:0];
            r_ovf     <= 1'b0;
            r_dbz_out <= 1'b1;
          end else begin
            r_quot    <= w_quot;
            r_rem     <= w_rem;
            r_ovf     <= w_ovf;
            r_dbz_out <= 1'b0;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.Quotient    = r_quot;
  assign bus.Remainder   = r_rem;
  assign bus.Overflow    = r_ovf;
  assign bus.Div_By_Zero = r_dbz_out;
  assign bus.Busy        = r_busy;
  assign bus.Done        = r_done;

endmodule

// File: tb/tb_divider_16x8_seq.sv
// tb/tb_divider_16x8_seq.sv - self-checking bench for the 16x8 sequential divider
module tb_divider_16x8_seq;

  typedef struct {
    logic        s;
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        ov;
    logic        dz;
    int          lat;
  } vec_t;

  logic Clk;
  logic Rst;
  int   total;
  int   bad;

  divider_16x8_seq_if bus ();

  divider_16x8_seq dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, remainder follows dividend.
  task automatic model(input logic s, input logic [15:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r,
                       output logic ov, output logic dz);
    int na, nb, tq, tr;
    if (b == 8'd0) begin
      q = 8'hFF; r = a[7:0]; ov = 1'b0; dz = 1'b1;
    end else begin
      dz = 1'b0;
      if (s) begin
        na = int'($signed(a));
        nb = int'($signed(b));
        tq = na / nb;
        tr = na % nb;
        ov = (tq > 127) || (tq < -128);
      end else begin
        na = int'(a);
        nb = int'(b);
        tq = na / nb;
        tr = na % nb;
        ov = (tq > 255);
      end
      q = tq[7:0];
      r = tr[7:0];
    end
  endtask

  // Issue one request (called just after an edge) and wait for Done; returns edges from Start sample.
  task automatic run_op(input logic s, input logic [15:0] a, input logic [7:0] b,
                        output logic [7:0] q, output logic [7:0] r,
                        output logic ov, output logic dz, output int lat);
    int   n;
    logic got;
    logic busy_bad;
    bus.Sign     = s;
    bus.Dividend = a;
    bus.Divisor  = b;
    bus.Start    = 1'b1;
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
    n = 0; got = 1'b0; busy_bad = 1'b0;
    while (!got && n < 40) begin
      @(posedge Clk);
      #1;
      n++;
      if (bus.Done) got = 1'b1;
      else if (!bus.Busy) busy_bad = 1'b1;
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("busy_during_op", 32'(busy_bad), 32'd0);
    chk("busy_low_at_done", 32'(bus.Busy), 32'd0);
    q = bus.Quotient; r = bus.Remainder; ov = bus.Overflow; dz = bus.Div_By_Zero;
    lat = n;
  endtask

  vec_t        vecs[12];
  logic [7:0]  q, r, eq, er;
  logic        ov, dz, eov, edz;
  int          lat;

  initial begin
    total = 0;
    bad   = 0;
    Rst = 1'b1;
    bus.Start = 1'b0; bus.Sign = 1'b0; bus.Dividend = '0; bus.Divisor = '0;

    vecs[0]  = '{1'b0, 16'h03E8, 8'h07, 8'h8E, 8'h06, 1'b0, 1'b0, 17};
    vecs[1]  = '{1'b1, 16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, 17};
    vecs[2]  = '{1'b1, 16'h0064, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, 17};
    vecs[3]  = '{1'b1, 16'hFF80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 17};
    vecs[4]  = '{1'b1, 16'h8000, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 17};
    vecs[5]  = '{1'b0, 16'h1000, 8'h02, 8'h00, 8'h00, 1'b1, 1'b0, 17};
    vecs[6]  = '{1'b0, 16'h1234, 8'h00, 8'hFF, 8'h34, 1'b0, 1'b1, 1};
    vecs[7]  = '{1'b0, 16'h0000, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0, 17};
    vecs[8]  = '{1'b1, 16'h0000, 8'hFB, 8'h00, 8'h00, 1'b0, 1'b0, 17};
    vecs[9]  = '{1'b1, 16'h1234, 8'h00, 8'hFF, 8'h34, 1'b0, 1'b1, 1};
    vecs[10] = '{1'b0, 16'hFFFF, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 17};
    vecs[11] = '{1'b1, 16'h7FFF, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 17};

    repeat (3) @(posedge Clk);
    #1;
    chk("rst_quotient", 32'(bus.Quotient), 32'd0);
    chk("rst_remainder", 32'(bus.Remainder), 32'd0);
    chk("rst_overflow", 32'(bus.Overflow), 32'd0);
    chk("rst_dbz", 32'(bus.Div_By_Zero), 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_done", 32'(bus.Done), 32'd0);
    Rst = 1'b0;

    // Directed table; each op starts in the previous Done cycle (back-to-back).
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, q, r, ov, dz, lat);
      chk($sformatf("vec%0d_quotient", i), 32'(q), 32'(vecs[i].q));
      chk($sformatf("vec%0d_remainder", i), 32'(r), 32'(vecs[i].r));
      chk($sformatf("vec%0d_overflow", i), 32'(ov), 32'(vecs[i].ov));
      chk($sformatf("vec%0d_dbz", i), 32'(dz), 32'(vecs[i].dz));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Start pulses while busy must be ignored.
    @(posedge Clk);
    #1;
    begin
      int   n, ndone, first;
      logic [7:0] fq, fr;
      bus.Sign = 1'b0; bus.Dividend = 16'h03E8; bus.Divisor = 8'h07; bus.Start = 1'b1;
      @(posedge Clk);
      #1;
      bus.Start = 1'b0;
      n = 0; ndone = 0; first = 0; fq = '0; fr = '0;
      while (n < 30) begin
        @(posedge Clk);
        #1;
        n++;
        bus.Start = 1'b0;
        if (bus.Done) begin
          ndone++;
          if (first == 0) begin
            first = n; fq = bus.Quotient; fr = bus.Remainder;
          end
        end
        if (n == 3 || n == 8) begin
          bus.Sign = 1'b1; bus.Dividend = 16'h0001; bus.Divisor = 8'h01; bus.Start = 1'b1;
        end
      end
      chk("ign_done_count", 32'(ndone), 32'd1);
      chk("ign_done_edge", 32'(first), 32'd17);
      chk("ign_quotient", 32'(fq), 32'h8E);
      chk("ign_remainder", 32'(fr), 32'h06);
    end

    // Explicit back-to-back: second request issued in the Done cycle of the first.
    run_op(1'b0, 16'h03E8, 8'h07, q, r, ov, dz, lat);
    run_op(1'b1, 16'hFF9C, 8'h07, q, r, ov, dz, lat);
    chk("b2b_latency", 32'(lat), 32'd17);
    chk("b2b_quotient", 32'(q), 32'hF2);
    chk("b2b_remainder", 32'(r), 32'hFE);

    // Reset five edges into CALC aborts the op silently.
    begin
      int ndone;
      bus.Sign = 1'b0; bus.Dividend = 16'h03E8; bus.Divisor = 8'h07; bus.Start = 1'b1;
      @(posedge Clk);
      #1;
      bus.Start = 1'b0;
      repeat (5) @(posedge Clk);
      #1;
      Rst = 1'b1;
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      chk("abort_busy", 32'(bus.Busy), 32'd0);
      chk("abort_done", 32'(bus.Done), 32'd0);
      chk("abort_quotient", 32'(bus.Quotient), 32'd0);
      chk("abort_remainder", 32'(bus.Remainder), 32'd0);
      chk("abort_overflow", 32'(bus.Overflow), 32'd0);
      chk("abort_dbz", 32'(bus.Div_By_Zero), 32'd0);
      ndone = 0;
      repeat (20) begin
        @(posedge Clk);
        #1;
        if (bus.Done) ndone++;
      end
      chk("abort_no_done", 32'(ndone), 32'd0);
      run_op(1'b0, 16'h00FF, 8'h10, q, r, ov, dz, lat);
      chk("post_abort_quotient", 32'(q), 32'h0F);
      chk("post_abort_remainder", 32'(r), 32'h0F);
      chk("post_abort_latency", 32'(lat), 32'd17);
    end

    // Randomised operands against the arithmetic reference.
    for (int k = 0; k < 150; k++) begin
      logic        rs;
      logic [15:0] ra;
      logic [7:0]  rb;
      rs = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      if ($urandom_range(0, 9) == 0) rb = 8'h00;
      else if ($urandom_range(0, 3) == 0) rb = 8'($urandom_range(1, 4));
      else rb = 8'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 16'($urandom_range(0, 600));
      model(rs, ra, rb, eq, er, eov, edz);
      run_op(rs, ra, rb, q, r, ov, dz, lat);
      chk($sformatf("rnd%0d_q s=%0d %h/%h", k, rs, ra, rb), 32'(q), 32'(eq));
      chk($sformatf("rnd%0d_r s=%0d %h/%h", k, rs, ra, rb), 32'(r), 32'(er));
      chk($sformatf("rnd%0d_ovf s=%0d %h/%h", k, rs, ra, rb), 32'(ov), 32'(eov));
      chk($sformatf("rnd%0d_dbz s=%0d %h/%h", k, rs, ra, rb), 32'(dz), 32'(edz));
      chk($sformatf("rnd%0d_lat", k), 32'(lat), edz ? 32'd1 : 32'd17);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
